// File: rtl/cpu8_pkg.sv
// Shared definitions for the 8-bit CPU slice: fetch FSM states, instruction
// geometry and the fetch timeout length used when FETCH_TIMEOUT_EN is defined.
package cpu8_pkg;

  localparam int INSTR_BYTES          = 2;
  localparam int FETCH_TIMEOUT_CYCLES = 16;
  localparam int WD_CNT_W             = $clog2(FETCH_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_OP  = 3'd1,
    FETCH_IMM = 3'd2,
    VALID     = 3'd3,
    ERR       = 3'd4
  } fetch_state_e;

  // Sequential successor of an instruction address; wraps naturally in 8 bits.
  function automatic logic [7:0] next_pc(input logic [7:0] pc_cur);
    return pc_cur + 8'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive non-ack cycles of one fetch phase and flags expiry on the
// cycle that would be the FETCH_TIMEOUT_CYCLES-th miss.
module fetch_watchdog
  import cpu8_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic ack_i,
  output logic expire_o
);

  logic [WD_CNT_W-1:0] cnt_q;

  // An ack always ends the current phase, so clearing on ack is the phase-entry reset.
  always_ff @(posedge clk) begin
    if (rst || !active_i || ack_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire_o = active_i && !ack_i &&
                    (cnt_q == WD_CNT_W'(FETCH_TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Two-byte instruction fetch unit: reads opcode at pc and immediate at pc+1,
// then holds them until the control unit advances or jumps.
// Optional fetch timeout with ERR state: define FETCH_TIMEOUT_EN.
// Memory handshake: mem_req/mem_addr are held until a single-cycle mem_ack,
// whose mem_rdata is captured in that same cycle.
module instr_fetch_unit
  import cpu8_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  output logic         mem_req,
  output logic [7:0]   mem_addr,
  input  logic [7:0]   mem_rdata,
  input  logic         mem_ack,
  output logic [7:0]   opcode,
  output logic [7:0]   imm,
  output logic         instr_valid,
  input  logic         pc_inc,
  input  logic         pc_load,
  input  logic [7:0]   jump_addr,
  output logic [7:0]   pc,
  output logic         fetch_err,
  output fetch_state_e dbg_state
);

  fetch_state_e state_q;
  logic [7:0]   pc_q;
  logic         mem_req_q;
  logic [7:0]   mem_addr_q;
  logic [7:0]   opcode_q;
  logic [7:0]   imm_q;
  logic         valid_q;
  logic [7:0]   pc_d;

  // pc_load wins over pc_inc.
  assign pc_d = pc_load ? jump_addr : next_pc(pc_q);

`ifdef FETCH_TIMEOUT_EN
  logic err_q;
  logic wd_expire;

  fetch_watchdog u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .active_i ((state_q == FETCH_OP) || (state_q == FETCH_IMM)),
    .ack_i    (mem_ack),
    .expire_o (wd_expire)
  );

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= 8'h00;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 8'h00;
      opcode_q   <= 8'h00;
      imm_q      <= 8'h00;
      valid_q    <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= FETCH_OP;
          mem_req_q  <= 1'b1;
          mem_addr_q <= pc_q;
        end
        FETCH_OP: begin
          if (mem_ack) begin
            opcode_q   <= mem_rdata;
            mem_addr_q <= pc_q + 8'd1;
            state_q    <= FETCH_IMM;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wd_expire) begin
            state_q   <= ERR;
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
          end
`endif
        end
        FETCH_IMM: begin
          if (mem_ack) begin
            imm_q     <= mem_rdata;
            mem_req_q <= 1'b0;
            valid_q   <= 1'b1;
            state_q   <= VALID;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (wd_expire) begin
            state_q   <= ERR;
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
          end
`endif
        end
        VALID: begin
          if (pc_load || pc_inc) begin
            pc_q       <= pc_d;
            valid_q    <= 1'b0;
            mem_req_q  <= 1'b1;
            mem_addr_q <= pc_d;
            state_q    <= FETCH_OP;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        ERR: begin
          state_q   <= ERR;
          mem_req_q <= 1'b0;
          valid_q   <= 1'b0;
        end
`endif
        default: begin
          state_q   <= IDLE;
          mem_req_q <= 1'b0;
          valid_q   <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign opcode      = opcode_q;
  assign imm         = imm_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory responder with programmable
// latency, instruction-level reference model and expected-instruction queue.
module tb_instr_fetch_unit;
  import cpu8_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         mem_req;
  logic [7:0]   mem_addr;
  logic [7:0]   mem_rdata;
  logic         mem_ack;
  logic [7:0]   opcode;
  logic [7:0]   imm;
  logic         instr_valid;
  logic         pc_inc = 1'b0;
  logic         pc_load = 1'b0;
  logic [7:0]   jump_addr = 8'h00;
  logic [7:0]   pc;
  logic         fetch_err;
  fetch_state_e dbg_state;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [256];
  logic [7:0]  model_pc = 8'h00;
  logic [23:0] exp_q[$];

  int         resp_lat = 1;
  bit         resp_hold = 1'b0;
  int         wait_cnt = 0;
  logic       resp_ack = 1'b0;
  logic [7:0] resp_rdata = 8'h00;
  logic       force_ack = 1'b0;
  logic [7:0] force_data = 8'h00;

  assign mem_ack   = resp_ack | force_ack;
  assign mem_rdata = force_ack ? force_data : resp_rdata;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .opcode     (opcode),
    .imm        (imm),
    .instr_valid(instr_valid),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .jump_addr  (jump_addr),
    .pc         (pc),
    .fetch_err  (fetch_err),
    .dbg_state  (dbg_state)
  );

  // Responder: acks after resp_lat idle cycles of a held request.
  always @(negedge clk) begin
    resp_ack   = 1'b0;
    resp_rdata = 8'($urandom);
    if (rst || !mem_req || resp_hold) begin
      wait_cnt = 0;
    end else if (wait_cnt >= resp_lat) begin
      resp_ack   = 1'b1;
      resp_rdata = mem[mem_addr];
      wait_cnt   = 0;
    end else begin
      wait_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout sim did not finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic expect_restart();
    logic [7:0] a1;
    model_pc = 8'h00;
    a1 = 8'h01;
    exp_q.delete();
    exp_q.push_back({mem[0], mem[a1], 8'h00});
  endtask

  // Issue an advance/jump from VALID and predict the next instruction.
  task automatic do_action(input bit inc, input bit load, input logic [7:0] ja);
    logic [7:0] n;
    logic [7:0] n1;
    n  = load ? ja : (model_pc + 8'd2);
    n1 = n + 8'd1;
    if (inc || load) begin
      model_pc = n;
      exp_q.push_back({mem[n], mem[n1], n});
    end
    pc_inc = inc; pc_load = load; jump_addr = ja;
    @(negedge clk);
    pc_inc = 1'b0; pc_load = 1'b0;
  endtask

  // Wait for instr_valid; optionally wiggle pc_inc/pc_load while not VALID.
  task automatic wait_valid(input int budget, input bit noise, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (instr_valid) begin
        pc_inc = 1'b0; pc_load = 1'b0;
        ok = 1'b1;
        return;
      end
      if (noise) begin
        pc_inc = 1'($urandom); pc_load = 1'($urandom); jump_addr = 8'($urandom);
      end
      @(negedge clk);
    end
    pc_inc = 1'b0; pc_load = 1'b0;
  endtask

  task automatic wait_state(input fetch_state_e s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (dbg_state == s) begin ok = 1'b1; return; end
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    pc_inc = 1'b1; pc_load = 1'b1; jump_addr = 8'h33;
    step(3);
    pc_inc = 1'b0; pc_load = 1'b0;
    checks++; if ({mem_req, mem_addr, instr_valid, fetch_err} !== 11'h0) begin
      failures++; $display("FAIL reset_mem got req=%b addr=%h v=%b err=%b exp all 0", mem_req, mem_addr, instr_valid, fetch_err); end
    checks++; if ({opcode, imm, pc} !== 24'h0) begin
      failures++; $display("FAIL reset_regs got op=%h imm=%h pc=%h exp 0", opcode, imm, pc); end
    checks++; if (dbg_state !== IDLE) begin
      failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_first_fetch();
    bit ok;
    logic [23:0] e;
    mem[0] = 8'h02; mem[1] = 8'h05;
    resp_lat = 1;
    expect_restart();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({mem_req, mem_addr} !== {1'b1, 8'h00} || dbg_state !== FETCH_OP) begin
      failures++; $display("FAIL first_req got req=%b addr=%h st=%0d exp req=1 addr=00 FETCH_OP", mem_req, mem_addr, dbg_state); end
    wait_valid(20, 1'b0, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || {opcode, imm, pc} !== 24'h020500 || e !== 24'h020500) begin
      failures++; $display("FAIL first_instr got ok=%b op=%h imm=%h pc=%h exp 02 05 00", ok, opcode, imm, pc); end
    // A stray ack and idle cycles in VALID must not disturb the held instruction.
    force_ack = 1'b1; force_data = 8'hAA;
    @(negedge clk);
    force_ack = 1'b0;
    step(3);
    checks++; if ({opcode, imm, pc, instr_valid} !== {24'h020500, 1'b1} || dbg_state !== VALID) begin
      failures++; $display("FAIL valid_hold got op=%h imm=%h pc=%h v=%b st=%0d exp 02 05 00 1", opcode, imm, pc, instr_valid, dbg_state); end
  endtask

  task automatic test_inc();
    bit ok;
    logic [23:0] e;
    do_action(1'b1, 1'b0, 8'h99);
    checks++; if ({pc, instr_valid, mem_addr, mem_req} !== {8'h02, 1'b0, 8'h02, 1'b1}) begin
      failures++; $display("FAIL inc_next got pc=%h v=%b addr=%h req=%b exp pc=02 v=0 addr=02 req=1", pc, instr_valid, mem_addr, mem_req); end
    wait_valid(20, 1'b0, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || {opcode, imm, pc} !== e) begin
      failures++; $display("FAIL inc_instr got ok=%b %h exp %h", ok, {opcode, imm, pc}, e); end
  endtask

  task automatic test_priority();
    bit ok;
    logic [23:0] e;
    do_action(1'b1, 1'b1, 8'h40);
    checks++; if ({pc, mem_addr, mem_req} !== {8'h40, 8'h40, 1'b1}) begin
      failures++; $display("FAIL prio_jump got pc=%h addr=%h req=%b exp 40 40 1", pc, mem_addr, mem_req); end
    wait_valid(20, 1'b0, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || {opcode, imm, pc} !== e) begin
      failures++; $display("FAIL prio_instr got ok=%b %h exp %h", ok, {opcode, imm, pc}, e); end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [23:0] e;
    do_action(1'b0, 1'b1, 8'hFE);
    wait_valid(20, 1'b0, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || {opcode, imm, pc} !== e) begin
      failures++; $display("FAIL wrap_fe got ok=%b %h exp %h", ok, {opcode, imm, pc}, e); end
    do_action(1'b1, 1'b0, 8'h00);
    checks++; if (pc !== 8'h00 || mem_addr !== 8'h00) begin
      failures++; $display("FAIL wrap_inc got pc=%h addr=%h exp 00 00", pc, mem_addr); end
    wait_valid(20, 1'b0, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || {opcode, imm, pc} !== e) begin
      failures++; $display("FAIL wrap_inc_instr got ok=%b %h exp %h", ok, {opcode, imm, pc}, e); end
    resp_lat = 2;
    do_action(1'b0, 1'b1, 8'hFF);
    checks++; if (mem_addr !== 8'hFF) begin
      failures++; $display("FAIL wrap_ff_op got addr=%h exp ff", mem_addr); end
    wait_state(FETCH_IMM, 20, ok);
    checks++; if (!ok || mem_addr !== 8'h00 || mem_req !== 1'b1) begin
      failures++; $display("FAIL wrap_ff_imm got ok=%b addr=%h req=%b exp addr=00 req=1", ok, mem_addr, mem_req); end
    wait_valid(20, 1'b0, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || {opcode, imm, pc} !== e) begin
      failures++; $display("FAIL wrap_ff_instr got ok=%b %h exp %h", ok, {opcode, imm, pc}, e); end
  endtask

  task automatic test_random();
    bit ok;
    logic [23:0] e;
    int sel;
    for (int it = 0; it < 24; it++) begin
      resp_lat = $urandom_range(0, 3);
      sel = $urandom_range(0, 2);
      do_action(sel != 1, sel != 0, 8'($urandom));
      wait_valid(40, 1'b1, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || {opcode, imm, pc} !== e) begin
        failures++; $display("FAIL rand_instr it=%0d got ok=%b %h exp %h", it, ok, {opcode, imm, pc}, e); end
    end
  endtask

  task automatic test_rst_mid_fetch();
    bit ok;
    logic [23:0] e;
    resp_lat = 0;
    mem[8'h42] = 8'h5A;
    do_action(1'b0, 1'b1, 8'h42);
    resp_hold = 1'b1;
    force_ack = 1'b1; force_data = mem[8'h42];
    @(negedge clk);
    force_ack = 1'b0;
    checks++; if (dbg_state !== FETCH_IMM || opcode !== 8'h5A) begin
      failures++; $display("FAIL mid_setup got st=%0d op=%h exp FETCH_IMM 5a", dbg_state, opcode); end
    rst = 1'b1; force_ack = 1'b1; force_data = 8'hC3;
    @(negedge clk);
    force_ack = 1'b0; resp_hold = 1'b0;
    checks++; if ({mem_req, mem_addr, opcode, imm, instr_valid, pc, fetch_err} !== 35'h0 || dbg_state !== IDLE) begin
      failures++; $display("FAIL mid_rst got req=%b addr=%h op=%h imm=%h v=%b pc=%h err=%b st=%0d exp all 0 IDLE",
                           mem_req, mem_addr, opcode, imm, instr_valid, pc, fetch_err, dbg_state); end
    step(1);
    resp_lat = 1;
    expect_restart();
    rst = 1'b0;
    wait_valid(20, 1'b0, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || {opcode, imm, pc} !== e) begin
      failures++; $display("FAIL mid_refetch got ok=%b %h exp %h", ok, {opcode, imm, pc}, e); end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [23:0] e;
    rst = 1'b1; step(2);
`ifdef FETCH_TIMEOUT_EN
    resp_lat = FETCH_TIMEOUT_CYCLES;
    rst = 1'b0;
    @(negedge clk);
    step(15);
    checks++; if (fetch_err !== 1'b0 || dbg_state !== FETCH_OP) begin
      failures++; $display("FAIL to_early got err=%b st=%0d exp 0 FETCH_OP", fetch_err, dbg_state); end
    step(1);
    checks++; if ({fetch_err, mem_req, instr_valid} !== 3'b100 || dbg_state !== ERR) begin
      failures++; $display("FAIL to_err got err=%b req=%b v=%b st=%0d exp 1 0 0 ERR", fetch_err, mem_req, instr_valid, dbg_state); end
    force_ack = 1'b1; pc_inc = 1'b1; pc_load = 1'b1;
    step(5);
    force_ack = 1'b0; pc_inc = 1'b0; pc_load = 1'b0;
    checks++; if ({fetch_err, mem_req} !== 2'b10 || dbg_state !== ERR) begin
      failures++; $display("FAIL to_sticky got err=%b req=%b st=%0d exp 1 0 ERR", fetch_err, mem_req, dbg_state); end
    rst = 1'b1; step(2);
    checks++; if (fetch_err !== 1'b0) begin
      failures++; $display("FAIL to_rst_clear got err=%b exp 0", fetch_err); end
    resp_lat = FETCH_TIMEOUT_CYCLES - 1;
    expect_restart();
    rst = 1'b0;
    wait_valid(80, 1'b0, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || {opcode, imm, pc} !== e || fetch_err !== 1'b0) begin
      failures++; $display("FAIL to_15_ok got ok=%b %h err=%b exp %h err=0", ok, {opcode, imm, pc}, fetch_err, e); end
`else
    resp_hold = 1'b1;
    expect_restart();
    rst = 1'b0;
    step(40);
    checks++; if (fetch_err !== 1'b0 || dbg_state !== FETCH_OP || mem_req !== 1'b1) begin
      failures++; $display("FAIL nto_wait got err=%b st=%0d req=%b exp 0 FETCH_OP 1", fetch_err, dbg_state, mem_req); end
    resp_hold = 1'b0; resp_lat = 1;
    wait_valid(20, 1'b0, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || {opcode, imm, pc} !== e || fetch_err !== 1'b0) begin
      failures++; $display("FAIL nto_fetch got ok=%b %h err=%b exp %h err=0", ok, {opcode, imm, pc}, fetch_err, e); end
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    test_reset();
    test_first_fetch();
    test_inc();
    test_priority();
    test_wrap();
    test_random();
    test_rst_mid_fetch();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
